fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_scan_controller.sv | 168 ++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with shadowed digit data,
// per-slot blanking, leading-zero suppression and a frame-wrap pulse.
module fnd_scan_controller #(
   parameter int SCAN_DIV = 100000,
   parameter int DEAD_CYC = 1000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic        i_load,
   input  logic [15:0] i_bcd,
   input  logic [3:0]  i_dp,
   input  logic        i_lzb,
   output logic [3:0]  o_digit,
   output logic [7:0]  o_font,
   output logic        o_frame
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int ON_CYC = SCAN_DIV - DEAD_CYC;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

   typedef enum logic {
      ST_OFF  = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [3:0]    dp_q, dp_d;
   logic [3:0]    digit_q, digit_d;
   logic [7:0]    font_q, font_d;
   logic          frame_q, frame_d;

   logic [3:0]    code_s;
   logic          upper_zero_s;
   logic [7:0]    cur_font_s;

   function automatic logic [7:0] seg_font(input logic [3:0] code);
      logic [7:0] f;
      case (code)
         4'h0:    f = 8'hC0;
         4'h1:    f = 8'hF9;
         4'h2:    f = 8'hA4;
         4'h3:    f = 8'hB0;
         4'h4:    f = 8'h99;
         4'h5:    f = 8'h92;
         4'h6:    f = 8'h82;
         4'h7:    f = 8'hF8;
         4'h8:    f = 8'h80;
         4'h9:    f = 8'h90;
         4'hA:    f = 8'h88;
         4'hB:    f = 8'h83;
         4'hC:    f = 8'hC6;
         4'hD:    f = 8'hA1;
         4'hE:    f = 8'h86;
         4'hF:    f = 8'h8E;
         default: f = 8'hFF;
      endcase
      return f;
   endfunction

   // Segment pattern for the digit currently selected by idx.
   always_comb begin
      code_s       = bcd_q[{idx_q, 2'b00} +: 4];
      upper_zero_s = 1'b0;
      case (idx_q)
         2'd3:    upper_zero_s = (bcd_q[15:12] == 4'h0);
         2'd2:    upper_zero_s = (bcd_q[15:8] == 8'h00);
         2'd1:    upper_zero_s = (bcd_q[15:4] == 12'h000);
         default: upper_zero_s = 1'b0;
      endcase
      if (i_lzb && upper_zero_s) begin
         cur_font_s = 8'hFF;
      end else begin
         cur_font_s = seg_font(code_s);
      end
      if (dp_q[idx_q]) begin
         cur_font_s[7] = 1'b0;
      end else begin
         cur_font_s[7] = cur_font_s[7];
      end
   end

   // Scan sequencing, shadow capture and next output values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bcd_d   = bcd_q;
      dp_d    = dp_q;
      digit_d = 4'hF;
      font_d  = 8'hFF;
      frame_d = 1'b0;

      if (i_load) begin
         bcd_d = i_bcd;
         dp_d  = i_dp;
      end else begin
         bcd_d = bcd_q;
         dp_d  = dp_q;
      end

      case (state_q)
         ST_OFF: begin
            cnt_d   = '0;
            idx_d   = 2'd0;
            state_d = i_en ? ST_SCAN : ST_OFF;
         end
         ST_SCAN: begin
            if (!i_en) begin
               state_d = ST_OFF;
               cnt_d   = '0;
               idx_d   = 2'd0;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d = '0;
               idx_d = idx_q + 2'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            // Dead phase leaves the defaults (all dark) in place.
            if (32'(cnt_q) < ON_CYC) begin
               digit_d = ~(4'b0001 << idx_q);
               font_d  = cur_font_s;
            end else begin
               digit_d = 4'hF;
               font_d  = 8'hFF;
            end
            frame_d = (cnt_q == CNT_MAX) && (idx_q == 2'd3);
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = 2'd0;
         end
      endcase
   end

   // State, shadow and output registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         bcd_q   <= 16'h0000;
         dp_q    <= 4'h0;
         digit_q <= 4'hF;
         font_q  <= 8'hFF;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bcd_q   <= bcd_d;
         dp_q    <= dp_d;
         digit_q <= digit_d;
         font_q  <= font_d;
         frame_q <= frame_d;
      end
   end

   assign o_digit = digit_q;
   assign o_font  = font_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench: directed display scenarios plus random traffic
// compared against a time-since-start reference model of the scanner.
module tb_fnd_scan_controller;

   localparam int SD = 8;
   localparam int DC = 2;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] bcd;
   logic [3:0]  dp;
   logic        lzb;
   logic [3:0]  digit;
   logic [7:0]  font;
   logic        frame;

   int n_checks;
   int n_err;

   // Reference model: scanning flag, cycles since scan start, shadow data.
   bit          m_scan;
   int          m_t;
   int          m_bcd [4];
   bit          m_dp [4];
   logic [7:0]  font_tab [16];

   logic [7:0]  rec_font [32];
   logic [3:0]  rec_dig [32];
   logic        rec_frm [32];

   fnd_scan_controller #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_en    (en),
      .i_load  (load),
      .i_bcd   (bcd),
      .i_dp    (dp),
      .i_lzb   (lzb),
      .o_digit (digit),
      .o_font  (font),
      .o_frame (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_font(input int slot);
      logic [7:0] f;
      bit blank;
      blank = (lzb == 1'b1) && (slot > 0);
      for (int j = slot; j < 4; j++) begin
         if (m_bcd[j] != 0) blank = 1'b0;
      end
      f = blank ? 8'hFF : font_tab[m_bcd[slot]];
      if (m_dp[slot]) f[7] = 1'b0;
      return f;
   endfunction

   // One clock: predict from pre-edge model and inputs, advance model, compare.
   task automatic step();
      logic [3:0] ed;
      logic [7:0] ef;
      logic       efr;
      int         slot;
      int         ph;
      ed  = 4'hF;
      ef  = 8'hFF;
      efr = 1'b0;
      if (!rst && m_scan) begin
         slot = (m_t / SD) % 4;
         ph   = m_t % SD;
         if (ph < SD - DC) begin
            for (int k = 0; k < 4; k++) ed[k] = (k != slot);
            ef = exp_font(slot);
         end
         efr = ((m_t % (4 * SD)) == (4 * SD - 1));
      end
      @(posedge clk);
      if (rst) begin
         m_scan = 1'b0;
         m_t    = 0;
         for (int k = 0; k < 4; k++) begin
            m_bcd[k] = 0;
            m_dp[k]  = 1'b0;
         end
      end else begin
         if (load) begin
            for (int k = 0; k < 4; k++) begin
               m_bcd[k] = int'((bcd >> (4 * k)) & 16'h000F);
               m_dp[k]  = dp[k];
            end
         end
         if (!en) begin
            m_scan = 1'b0;
            m_t    = 0;
         end else if (m_scan) begin
            m_t++;
         end else begin
            m_scan = 1'b1;
            m_t    = 0;
         end
      end
      @(negedge clk);
      check("digit", 32'(digit), 32'(ed));
      check("font", 32'(font), 32'(ef));
      check("frame", 32'(frame), 32'(efr));
      check("onehot", 32'($countones(~digit) <= 1), 32'd1);
   endtask

   task automatic start(input logic [15:0] b, input logic [3:0] d);
      rst = 1'b1; en = 1'b0; load = 1'b0; step();
      rst = 1'b0; load = 1'b1; bcd = b; dp = d; step();
      load = 1'b0; en = 1'b1; step();
   endtask

   task automatic capture32();
      for (int k = 0; k < 32; k++) begin
         step();
         rec_font[k] = font;
         rec_dig[k]  = digit;
         rec_frm[k]  = frame;
      end
   endtask

   initial begin
      int nfrm;
      font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      n_checks = 0; n_err = 0;
      m_scan = 1'b0; m_t = 0;
      for (int k = 0; k < 4; k++) begin m_bcd[k] = 0; m_dp[k] = 1'b0; end
      rst = 1'b1; en = 1'b0; load = 1'b0; bcd = 16'h0; dp = 4'h0; lzb = 1'b0;
      @(negedge clk);
      step();
      check("rst_digit", 32'(digit), 32'h F);
      check("rst_font", 32'(font), 32'h FF);
      check("rst_frame", 32'(frame), 32'h0);

      // Basic scan of 1234.
      start(16'h1234, 4'h0);
      capture32();
      check("s1_d0", 32'(rec_font[0]), 32'h99);
      check("s1_d1", 32'(rec_font[8]), 32'hB0);
      check("s1_d2", 32'(rec_font[16]), 32'hA4);
      check("s1_d3", 32'(rec_font[24]), 32'hF9);
      check("s1_on", 32'(rec_dig[5]), 32'hE);
      check("s1_dead", 32'(rec_dig[6]), 32'hF);
      check("s1_dead_font", 32'(rec_font[7]), 32'hFF);
      check("s1_dig3", 32'(rec_dig[29]), 32'h7);
      nfrm = 0;
      for (int k = 0; k < 32; k++) nfrm += int'(rec_frm[k]);
      check("s1_frm_cnt", 32'(nfrm), 32'd1);
      check("s1_frm_pos", 32'(rec_frm[31]), 32'd1);

      // Leading-zero blanking on 0007.
      lzb = 1'b1;
      start(16'h0007, 4'h0);
      capture32();
      check("lzb_d0", 32'(rec_font[0]), 32'hF8);
      check("lzb_d1", 32'(rec_font[8]), 32'hFF);
      check("lzb_d1_en", 32'(rec_dig[8]), 32'hD);
      check("lzb_d3", 32'(rec_font[24]), 32'hFF);
      lzb = 1'b0;
      capture32();
      check("nolzb_d1", 32'(rec_font[8]), 32'hC0);
      check("nolzb_d3", 32'(rec_font[24]), 32'hC0);

      // Blanking with dp and a nonzero middle digit.
      lzb = 1'b1;
      start(16'h00A0, 4'b0010);
      capture32();
      check("dp_d0", 32'(rec_font[0]), 32'hC0);
      check("dp_d1", 32'(rec_font[8]), 32'h08);
      check("dp_d2", 32'(rec_font[16]), 32'hFF);
      check("dp_d3", 32'(rec_font[24]), 32'hFF);
      lzb = 1'b0;

      // Mid-slot load takes effect at once without stretching the slot.
      start(16'h1234, 4'h0);
      repeat (3) step();
      load = 1'b1; bcd = 16'hFFFF; dp = 4'h0; step();
      check("ml_old", 32'(font), 32'h99);
      load = 1'b0; step();
      check("ml_new", 32'(font), 32'h8E);
      repeat (3) step();
      step();
      check("ml_next_slot", 32'(digit), 32'hD);

      // Enable dropped mid-slot, then restored.
      start(16'h1234, 4'h0);
      repeat (3) step();
      en = 1'b0; step();
      check("off_lag", 32'(digit), 32'hE);
      step();
      check("off_dig", 32'(digit), 32'hF);
      check("off_font", 32'(font), 32'hFF);
      en = 1'b1; step();
      for (int k = 0; k < 6; k++) begin
         step();
         check("restart_on", 32'(digit), 32'hE);
      end
      step();
      check("restart_dead", 32'(digit), 32'hF);

      // Reset during the digit-2 ON phase.
      start(16'h1234, 4'h0);
      repeat (19) step();
      rst = 1'b1; step();
      check("mrst_dig", 32'(digit), 32'hF);
      check("mrst_font", 32'(font), 32'hFF);
      rst = 1'b0; step();
      step();
      check("mrst_restart", 32'(digit), 32'hE);
      check("mrst_shadow", 32'(font), 32'hC0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst  = ($urandom_range(499, 0) == 0);
         if ($urandom_range(59, 0) == 0) en = ~en;
         if ($urandom_range(39, 0) == 0) lzb = ~lzb;
         load = ($urandom_range(9, 0) == 0);
         for (int k = 0; k < 4; k++) begin
            bcd[4*k +: 4] = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 0));
         end
         dp = 4'($urandom_range(15, 0));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
